uart_mmio_bridge: RTL
=====================

# uart_mmio_bridge

Memory-mapped UART peripheral front end between the RV32I data bus and the UART core. It buffers received bytes in an 8-deep RX FIFO and exposes data, status and control registers to the single-cycle core. It also hands transmit bytes to the UART core through a start/busy handshake. It consumes the UART core's received-byte stream and feeds its transmitter.

## Interface
- FIFO_DEPTH, 8, RX FIFO entries; power of two, 2..16
- clk  in  1  system clock, rising-edge active
- rst  in  1  asynchronous, active-high reset
- bus_addr  in  4  byte offset within the peripheral; bits [3:2] select the register, bits [1:0] are ignored
- bus_we  in  1  register write strobe, one cycle per store
- bus_re  in  1  register read strobe, one cycle per load
- bus_wdata  in  32  write data
- bus_rdata  out  32  read data, combinational from bus_addr and current state
- rx_data  in  8  received byte from the UART core
- rx_valid  in  1  one-cycle pulse, rx_data valid
- tx_data  out  8  byte to transmit
- tx_start  out  1  one-cycle transmit request to the UART core
- tx_busy  in  1  UART core transmitter active
- irq  out  1  registered RX interrupt

## Operation
- Register map (offset):
  - 0x0 RXDATA: read returns {24'b0, head byte} and pops the byte; reading when empty returns 0 and causes no pop.
  - 0x4 TXDATA: write loads bus_wdata[7:0] when tx_ready=1; ignored otherwise; reads return 0.
  - 0x8 STATUS (read-only): [0] rx_avail, [1] rx_full, [2] overrun, [3] tx_ready, [8:4] rx_count (0..FIFO_DEPTH); all other bits 0.
  - 0xC CTRL: [0] rx_irq_en (read/write); writing 1 to bit [1] clears overrun; bit [1] reads 0.
- RX FIFO: read/write pointers are log2(FIFO_DEPTH)+1 bits wide; the extra MSB is the wrap flag. full = indices equal and wrap bits differ; empty = pointers equal. Pointers increment modulo 2·FIFO_DEPTH.
- Push on rx_valid when not full.
  - rx_valid while full with no pop: the byte is dropped and overrun sets (sticky).
  - Push and pop in the same cycle while full: both take effect, count stays FIFO_DEPTH, no overrun.
  - Push and pop in the same cycle while empty: the push takes effect, the pop is ignored, and the read returns 0.
- An overrun set event and a CTRL clear in the same cycle: set wins.
- TX FSM, states IDLE, START, WAIT_BUSY, WAIT_DONE:
  - IDLE → START on an accepted TXDATA write; tx_data is latched.
  - START asserts tx_start for exactly one cycle, then → WAIT_BUSY.
  - WAIT_BUSY → WAIT_DONE when tx_busy=1.
  - WAIT_DONE → IDLE when tx_busy=0.
- tx_ready = (state==IDLE).
- irq register loads rx_irq_en & !empty on every clock.

## Timing
- Reset values: FIFO empty, overrun=0, rx_irq_en=0, TX FSM=IDLE, tx_data=0x00, tx_start=0, irq=0. After reset, STATUS reads 0x0000_0008.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge. tx_start drops at once. Bytes held in the FIFO are lost.
- bus_rdata is combinational, so a load completes in one core cycle. The pop takes effect at the rising edge that ends the bus_re cycle.
- rx_valid at edge N: rx_avail and rx_count reflect the byte after edge N; irq reflects it after edge N+1.
- TXDATA write at edge N: tx_start is high during cycle N+1. The earliest next accepted write is one cycle after WAIT_DONE → IDLE.
- bus_re and bus_we asserted together: both are honoured. A write to RXDATA or STATUS has no effect.

## Structure
- uart_pkg holds:
  - register offset constants UART_RXDATA_OFS, UART_TXDATA_OFS, UART_STATUS_OFS, UART_CTRL_OFS;
  - STATUS bit-position constants;
  - enum tx_state_t {TX_IDLE, TX_START, TX_WAIT_BUSY, TX_WAIT_DONE}.
- One sub-module, sync_fifo, parameterised on WIDTH and DEPTH, providing push, pop, full, empty, count and a combinational head output. Register decode and the TX FSM live in uart_mmio_bridge.

## Test plan
- Reset, then read 0x8 → 0x0000_0008; irq=0, tx_start=0.
- rx_valid with 0x41, then 0x42; read 0x8 → rx_count=2, rx_avail=1; read 0x0 twice → 0x41, then 0x42; a third read → 0x0, rx_count stays 0.
- Push 9 bytes 0x01..0x09 without reads → rx_full=1, overrun=1, rx_count=8. Drain the FIFO → 0x01..0x08. Write 0x2 to CTRL → overrun=0.
- With the FIFO full, issue rx_valid 0xAA and an RXDATA read in the same cycle → the read returns the old head, count stays 8, overrun stays 0, and 0xAA is the last byte drained.
- Write 0x55 to TXDATA → tx_data=0x55 with a one-cycle tx_start pulse on the next cycle. Model tx_busy high for 20 cycles: a second write during busy is ignored (exactly one tx_start pulse total); tx_ready=1 after tx_busy falls.
- Set rx_irq_en=1, push 0x10 → irq rises one cycle after rx_avail. Pulse rst in WAIT_BUSY → FSM returns to IDLE and irq=0 asynchronously.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and types for the UART MMIO bridge: register offsets,
// STATUS/CTRL bit positions, TX handshake states and a STATUS packer.
package uart_pkg;

    // Register byte offsets; only bits [3:2] take part in decode
    localparam logic [3:0] UART_RXDATA_OFS = 4'h0;
    localparam logic [3:0] UART_TXDATA_OFS = 4'h4;
    localparam logic [3:0] UART_STATUS_OFS = 4'h8;
    localparam logic [3:0] UART_CTRL_OFS   = 4'hC;

    // STATUS bit positions
    localparam int unsigned STAT_RX_AVAIL_BIT = 0;
    localparam int unsigned STAT_RX_FULL_BIT  = 1;
    localparam int unsigned STAT_OVERRUN_BIT  = 2;
    localparam int unsigned STAT_TX_READY_BIT = 3;
    localparam int unsigned STAT_RX_COUNT_LSB = 4;
    localparam int unsigned STAT_RX_COUNT_W   = 5;

    // CTRL bit positions
    localparam int unsigned CTRL_IRQ_EN_BIT  = 0;
    localparam int unsigned CTRL_OVR_CLR_BIT = 1;

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_START     = 2'd1,
        TX_WAIT_BUSY = 2'd2,
        TX_WAIT_DONE = 2'd3
    } tx_state_t;

    // Assemble the STATUS word; unused bits are zero
    function automatic logic [31:0] pack_status(
        input logic       rx_avail,
        input logic       rx_full,
        input logic       overrun,
        input logic       tx_ready,
        input logic [4:0] rx_count
    );
        logic [31:0] s;
        s = 32'd0;
        s[STAT_RX_AVAIL_BIT] = rx_avail;
        s[STAT_RX_FULL_BIT]  = rx_full;
        s[STAT_OVERRUN_BIT]  = overrun;
        s[STAT_TX_READY_BIT] = tx_ready;
        s[STAT_RX_COUNT_LSB +: STAT_RX_COUNT_W] = rx_count;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-flag pointers and a combinational head output.
// A pop while empty is ignored; a push while full is accepted only when an
// effective pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign count     = wr_ptr_r - rd_ptr_r;
    assign head      = mem_r[rd_ptr_r[AW-1:0]];
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    // Pointer update; natural PW-bit wrap gives modulo 2*DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
        end
    end

    // Storage write; contents need no reset because the pointers gate them
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/uart_mmio_bridge.sv
// Memory-mapped UART front end: RX FIFO with status/overrun/irq, register
// decode for the core's data bus, and the TX start/busy handshake FSM.
module uart_mmio_bridge
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  bus_addr,
    input  logic        bus_we,
    input  logic        bus_re,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        irq
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    tx_state_t        tx_state_r;
    logic             overrun_r;
    logic             rx_irq_en_r;
    logic [3:0]       reg_ofs_s;
    logic             rd_rxdata_s;
    logic             wr_txdata_s;
    logic             wr_ctrl_s;
    logic             tx_ready_s;
    logic             tx_accept_s;
    logic             overrun_set_s;
    logic [7:0]       fifo_head_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic [31:0]      status_s;
    logic             unused_s;

    assign reg_ofs_s     = {bus_addr[3:2], 2'b00};
    assign rd_rxdata_s   = bus_re & (reg_ofs_s == UART_RXDATA_OFS);
    assign wr_txdata_s   = bus_we & (reg_ofs_s == UART_TXDATA_OFS);
    assign wr_ctrl_s     = bus_we & (reg_ofs_s == UART_CTRL_OFS);
    assign tx_ready_s    = (tx_state_r == TX_IDLE);
    assign tx_accept_s   = wr_txdata_s & tx_ready_s;
    // A full FIFO is never empty, so a read here always frees a slot
    assign overrun_set_s = rx_valid & fifo_full_s & ~rd_rxdata_s;
    assign status_s      = pack_status(~fifo_empty_s, fifo_full_s, overrun_r,
                                       tx_ready_s, 5'(fifo_count_s));
    assign unused_s      = &{1'b0, bus_addr[1:0], bus_wdata[31:8]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_valid),
        .pop   (rd_rxdata_s),
        .wdata (rx_data),
        .head  (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Sticky overrun (set beats clear), irq enable and registered interrupt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_r   <= 1'b0;
            rx_irq_en_r <= 1'b0;
            irq         <= 1'b0;
        end else begin
            if (overrun_set_s) begin
                overrun_r <= 1'b1;
            end else if (wr_ctrl_s && bus_wdata[CTRL_OVR_CLR_BIT]) begin
                overrun_r <= 1'b0;
            end
            if (wr_ctrl_s) begin
                rx_irq_en_r <= bus_wdata[CTRL_IRQ_EN_BIT];
            end
            irq <= rx_irq_en_r & ~fifo_empty_s;
        end
    end

    // TX handshake FSM with registered tx_data / tx_start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_r <= TX_IDLE;
            tx_data    <= 8'h00;
            tx_start   <= 1'b0;
        end else begin
            case (tx_state_r)
                TX_IDLE: begin
                    if (tx_accept_s) begin
                        tx_data    <= bus_wdata[7:0];
                        tx_start   <= 1'b1;
                        tx_state_r <= TX_START;
                    end
                end
                TX_START: begin
                    tx_start   <= 1'b0;
                    tx_state_r <= TX_WAIT_BUSY;
                end
                TX_WAIT_BUSY: begin
                    if (tx_busy) begin
                        tx_state_r <= TX_WAIT_DONE;
                    end
                end
                TX_WAIT_DONE: begin
                    if (!tx_busy) begin
                        tx_state_r <= TX_IDLE;
                    end
                end
                default: begin
                    tx_start   <= 1'b0;
                    tx_state_r <= TX_IDLE;
                end
            endcase
        end
    end

    // Combinational read mux; an empty FIFO reads as zero
    always_comb begin
        bus_rdata = 32'd0;
        case (reg_ofs_s)
            UART_RXDATA_OFS: begin
                if (fifo_empty_s) begin
                    bus_rdata = 32'd0;
                end else begin
                    bus_rdata = {24'd0, fifo_head_s};
                end
            end
            UART_TXDATA_OFS: bus_rdata = 32'd0;
            UART_STATUS_OFS: bus_rdata = status_s;
            UART_CTRL_OFS:   bus_rdata = {31'd0, rx_irq_en_r};
            default:         bus_rdata = 32'd0;
        endcase
    end

endmodule
